// File: rtl/sound_event_scheduler_if.sv
// Handshake bundle between the game logic and the sound event scheduler.
interface sound_event_scheduler_if;
  logic       counterClk;
  logic [5:0] req;
  logic       engine_on;
  logic [3:0] engine_tone;
  logic       mute;
  logic       EnableSound;
  logic [3:0] tone;
  logic       busy;
  logic [2:0] active_id;
  logic [5:0] pending;

  modport master (
    output counterClk, req, engine_on, engine_tone, mute,
    input  EnableSound, tone, busy, active_id, pending
  );

  modport slave (
    input  counterClk, req, engine_on, engine_tone, mute,
    output EnableSound, tone, busy, active_id, pending
  );
endinterface

// File: rtl/sound_event_scheduler.sv
// Fixed-priority sound event arbiter and melody sequencer feeding the shared tone generator.
// Optional SOUND_PREEMPT_EN: a lower-index pending request aborts the melody in progress.
module sound_event_scheduler #(
  parameter int unsigned STEP_TICKS = 7,
  parameter int unsigned GAP_TICKS  = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  sound_event_scheduler_if.slave sif
);

  localparam int unsigned N_REQ  = 6;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned TONE_W = 4;
  localparam logic [ID_W-1:0] NO_ID = ID_W'(7);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t             state, state_n;
  logic [N_REQ-1:0]   pend_q, pend_n;
  logic [ID_W-1:0]    id_q, id_n;
  logic [IDX_W-1:0]   note_q, note_n;
  logic [CNT_W-1:0]   tick_q, tick_n;
  logic [CNT_W-1:0]   gap_q, gap_n;
  logic               grant;
  logic [ID_W-1:0]    gnt_id;

  logic [TONE_W-1:0]  tone_q, tone_n;
  logic               en_q, en_n;
  logic               busy_q, busy_n;
  logic [ID_W-1:0]    act_q, act_n;

  // Melody note table; win/newGame share an ascending run from 6.
  function automatic logic [TONE_W-1:0] note_tone(input logic [ID_W-1:0] id,
                                                  input logic [IDX_W-1:0] idx);
    logic [TONE_W-1:0] t;
    t = '0;
    case (id)
      3'd0: begin
        case (idx)
          3'd0:    t = 4'd9;
          3'd1:    t = 4'd10;
          default: t = 4'd10 - TONE_W'(idx);
        endcase
      end
      3'd1, 3'd2: t = 4'd6 + TONE_W'(idx);
      3'd3:       t = 4'd15 - TONE_W'(idx);
      3'd4: begin
        case (idx[1:0])
          2'd0:    t = 4'd2;
          2'd1:    t = 4'd3;
          2'd2:    t = 4'd0;
          default: t = 4'd1;
        endcase
      end
      3'd5: begin
        case (idx[1:0])
          2'd0:    t = 4'd2;
          2'd1:    t = 4'd6;
          2'd2:    t = 4'd7;
          default: t = 4'd6;
        endcase
      end
      default: t = '0;
    endcase
    return t;
  endfunction

  function automatic logic [IDX_W-1:0] last_idx(input logic [ID_W-1:0] id);
    return (id <= ID_W'(1)) ? IDX_W'(7) : IDX_W'(3);
  endfunction

  function automatic logic [ID_W-1:0] lowest_set(input logic [N_REQ-1:0] p);
    logic [ID_W-1:0] r;
    r = NO_ID;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (p[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  // Next-state, arbitration and next-output decode
  always_comb begin
    state_n = state;
    pend_n  = pend_q | sif.req;
    id_n    = id_q;
    note_n  = note_q;
    tick_n  = tick_q;
    gap_n   = gap_q;
    grant   = 1'b0;
    gnt_id  = lowest_set(pend_q);

    case (state)
      IDLE: begin
        if (pend_q != '0) grant = 1'b1;
      end
      PLAY: begin
        if (sif.counterClk) begin
          if (tick_q == CNT_W'(STEP_TICKS - 1)) begin
            tick_n = '0;
            if (note_q == last_idx(id_q)) begin
              state_n = GAP;
              gap_n   = '0;
            end else begin
              note_n = note_q + IDX_W'(1);
            end
          end else begin
            tick_n = tick_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (sif.counterClk) begin
          if (gap_q == CNT_W'(GAP_TICKS - 1)) state_n = IDLE;
          else                                gap_n   = gap_q + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef SOUND_PREEMPT_EN
    if (state != IDLE && gnt_id < id_q) grant = 1'b1;
`endif

    // A same-cycle request on the granted bit re-arms it
    if (grant) begin
      pend_n  = (pend_q & ~(N_REQ'(1) << gnt_id)) | sif.req;
      id_n    = gnt_id;
      note_n  = '0;
      tick_n  = '0;
      state_n = PLAY;
    end

    tone_n = '0;
    en_n   = 1'b0;
    busy_n = 1'b0;
    act_n  = NO_ID;
    case (state_n)
      IDLE: begin
        if (sif.engine_on) begin
          tone_n = sif.engine_tone;
          en_n   = 1'b1;
        end
      end
      PLAY: begin
        tone_n = note_tone(id_n, note_n);
        en_n   = 1'b1;
        busy_n = 1'b1;
        act_n  = id_n;
      end
      GAP: begin
        busy_n = 1'b1;
        act_n  = id_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state  <= IDLE;
      pend_q <= '0;
      id_q   <= NO_ID;
      note_q <= '0;
      tick_q <= '0;
      gap_q  <= '0;
      tone_q <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      act_q  <= NO_ID;
    end else begin
      state  <= state_n;
      pend_q <= pend_n;
      id_q   <= id_n;
      note_q <= note_n;
      tick_q <= tick_n;
      gap_q  <= gap_n;
      tone_q <= tone_n;
      en_q   <= en_n & ~sif.mute;
      busy_q <= busy_n;
      act_q  <= act_n;
    end
  end

  assign sif.EnableSound = en_q;
  assign sif.tone        = tone_q;
  assign sif.busy        = busy_q;
  assign sif.active_id   = act_q;
  assign sif.pending     = pend_q;

endmodule
